ternary_mv_ctrl: RTL and testbench



---
 rtl/ternary_pkg.sv | 30 +++
 rtl/ternary_w_loader.sv | 31 +++
 rtl/ternary_mv_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ternary_mv_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ternary_pkg.sv
// Shared definitions for the ternary matrix-vector multiplier and its sequencer.
package ternary_pkg;

    // Matrix geometry: IN_LEN inputs (rows) by OUT_LEN outputs (columns).
    localparam int IN_LEN    = 16;
    localparam int OUT_LEN   = 8;
    localparam int BIT_WIDTH = 8;

    // Derived sizes.
    localparam int W_BITS    = 2 * IN_LEN * OUT_LEN;
    localparam int W_BYTES   = W_BITS / 8;
    localparam int PAIRS     = IN_LEN / 2;
    localparam int W_CNT_W   = $clog2(W_BYTES);
    localparam int X_CNT_W   = $clog2(IN_LEN + 1);
    localparam int X_IDX_W   = $clog2(IN_LEN);
    localparam int PH_W      = $clog2((PAIRS > OUT_LEN) ? PAIRS : OUT_LEN);

    // Ternary weight encodings; any other code means zero.
    localparam logic [1:0] W_POS = 2'b01;
    localparam logic [1:0] W_NEG = 2'b11;

    // Sequencer states.
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/ternary_w_loader.sv
// Byte-wide weight loader: a wrapping byte counter writes successive bytes of
// the weight matrix register, which directly drives the multiplier weights.
module ternary_w_loader
    import ternary_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                accept,
    input  logic [7:0]          data,
    output logic [W_BITS-1:0]   w_mat,
    output logic [W_CNT_W-1:0]  count,
    output logic                loaded
);

    // Byte k lands at bits [8k+7:8k]; loaded latches on the final byte and
    // stays set through later partial reloads (the caller gates on count).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_mat  <= '0;
            count  <= '0;
            loaded <= 1'b0;
        end else if (accept) begin
            w_mat[{count, 3'b000} +: 8] <= data;
            count <= count + 1'b1;
            if (count == W_CNT_W'(W_BYTES - 1)) begin
                loaded <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ternary_mv_ctrl.sv
// Sequencer for the ternary matrix-vector multiplier: collects weights and an
// input vector, runs one compute pass, drains the serial results and streams
// them out.
//
// Handshakes: every stream transfers a byte on a rising clk edge where both
// valid and ready are high; a producer holds valid and data stable until that
// edge, and ready may be asserted independently of valid.
module ternary_mv_ctrl
    import ternary_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic [7:0]             w_data,
    input  logic                   x_valid,
    output logic                   x_ready,
    input  logic [BIT_WIDTH-1:0]   x_data,
    output logic                   y_valid,
    input  logic                   y_ready,
    output logic [BIT_WIDTH-1:0]   y_data,
    output logic                   mult_en,
    output logic [2*BIT_WIDTH-1:0] mult_vec_in,
    output logic [W_BITS-1:0]      mult_w,
    input  logic [BIT_WIDTH-1:0]   mult_vec_out,
    input  logic                   mult_set,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output state_t                 fsm_state,
    output logic                   w_loaded
);

    state_t               state_q, state_d;
    logic [PH_W-1:0]      phase_q, phase_d;
    logic [BIT_WIDTH-1:0] x_buf [IN_LEN];
    logic [BIT_WIDTH-1:0] y_buf [OUT_LEN];
    logic [X_CNT_W-1:0]   x_count;
    logic [W_CNT_W-1:0]   w_count;
    logic                 x_full;
    logic                 start;
    logic                 last_run;
    logic                 last_out;
    logic                 x_accept;
    logic                 w_accept;
    logic                 y_accept;

    assign x_full   = (x_count == X_CNT_W'(IN_LEN));
    assign start    = x_full && w_loaded && (w_count == '0);
    assign last_run = (phase_q == PH_W'(PAIRS - 1));
    assign last_out = (phase_q == PH_W'(OUT_LEN - 1));
    assign x_accept = x_valid && x_ready;
    assign w_accept = w_valid && w_ready;
    assign y_accept = y_valid && y_ready;

    assign busy      = (state_q != LOAD);
    assign fsm_state = state_q;

    ternary_w_loader u_w_loader (
        .clk    (clk),
        .rst_n  (rst_n),
        .accept (w_accept),
        .data   (w_data),
        .w_mat  (mult_w),
        .count  (w_count),
        .loaded (w_loaded)
    );

    // State and phase registers; reset drops straight back to LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // Next-state logic plus all stream and multiplier controls, decoded
    // directly from state/phase so mult_en follows the async reset.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        mult_en     = 1'b0;
        mult_vec_in = '0;
        y_valid     = 1'b0;
        y_data      = '0;
        done        = 1'b0;
        w_ready     = 1'b0;
        x_ready     = 1'b0;
        case (state_q)
            LOAD: begin
                w_ready = 1'b1;
                x_ready = !x_full;
                if (start) begin
                    state_d = RUN;
                    phase_d = '0;
                end
            end
            RUN: begin
                mult_en     = 1'b1;
                mult_vec_in = {x_buf[{phase_q, 1'b0}], x_buf[{phase_q, 1'b1}]};
                if (last_run) begin
                    state_d = DRAIN;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            DRAIN: begin
                // Enable stays high with a zero pair while results stream back.
                mult_en = 1'b1;
                if (last_out) begin
                    state_d = OUT;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            OUT: begin
                w_ready = 1'b1;
                y_valid = 1'b1;
                y_data  = y_buf[phase_q];
                if (y_ready) begin
                    if (last_out) begin
                        done    = 1'b1;
                        state_d = LOAD;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = LOAD;
                phase_d = '0;
            end
        endcase
    end

    // Input vector buffer; the count is cleared once the result vector is sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_count <= '0;
            for (int i = 0; i < IN_LEN; i++) begin
                x_buf[i] <= '0;
            end
        end else if (state_q == OUT && y_accept && last_out) begin
            x_count <= '0;
        end else if (x_accept) begin
            x_buf[x_count[X_IDX_W-1:0]] <= x_data;
            x_count <= x_count + 1'b1;
        end
    end

    // Capture one multiplier result per DRAIN cycle; a missing result-valid
    // is latched as a sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
            for (int i = 0; i < OUT_LEN; i++) begin
                y_buf[i] <= '0;
            end
        end else if (state_q == DRAIN) begin
            y_buf[phase_q] <= mult_vec_out;
            if (!mult_set) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ternary_mv_ctrl.sv
// Directed bench for ternary_mv_ctrl with a behavioural multiplier model.
module tb_ternary_mv_ctrl;
    import ternary_pkg::*;

    localparam int LIMIT = 200;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                   w_valid, w_ready, x_valid, x_ready;
    logic                   y_valid, y_ready;
    logic [7:0]             w_data, x_data, y_data;
    logic                   mult_en, mult_set, busy, done, err, w_loaded;
    logic [15:0]            mult_vec_in;
    logic [W_BITS-1:0]      mult_w;
    logic [7:0]             mult_vec_out;
    state_t                 fsm_state;

    ternary_mv_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_data       (w_data),
        .x_valid      (x_valid),
        .x_ready      (x_ready),
        .x_data       (x_data),
        .y_valid      (y_valid),
        .y_ready      (y_ready),
        .y_data       (y_data),
        .mult_en      (mult_en),
        .mult_vec_in  (mult_vec_in),
        .mult_w       (mult_w),
        .mult_vec_out (mult_vec_out),
        .mult_set     (mult_set),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .fsm_state    (fsm_state),
        .w_loaded     (w_loaded)
    );

    // ---------------- multiplier model ----------------
    int                  m_cnt = 0;
    logic [8*IN_LEN-1:0] m_x = '0;
    logic                drop_set = 1'b0;

    function automatic logic [7:0] col_sum(input logic [W_BITS-1:0] w,
                                           input logic [8*IN_LEN-1:0] xv,
                                           input int c);
        logic [7:0] acc;
        logic [1:0] code;
        acc = 8'h00;
        for (int r = 0; r < IN_LEN; r++) begin
            code = w[2*(r*OUT_LEN+c) +: 2];
            if (code == W_POS) acc = acc + xv[8*r +: 8];
            else if (code == W_NEG) acc = acc - xv[8*r +: 8];
        end
        return acc;
    endfunction

    always @(posedge clk) begin
        if (!mult_en) begin
            m_cnt <= 0;
        end else begin
            if (m_cnt < PAIRS) begin
                m_x[16*m_cnt +: 8]     <= mult_vec_in[15:8];
                m_x[16*m_cnt + 8 +: 8] <= mult_vec_in[7:0];
            end
            m_cnt <= m_cnt + 1;
        end
    end

    always_comb begin
        mult_set     = 1'b0;
        mult_vec_out = 8'h00;
        if (mult_en && m_cnt >= PAIRS && m_cnt < PAIRS + OUT_LEN) begin
            mult_set     = !(drop_set && m_cnt == PAIRS + 2);
            mult_vec_out = col_sum(mult_w, m_x, m_cnt - PAIRS);
        end
    end

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_w(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        w_valid = 1'b1;
        w_data  = b;
        while (!w_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("w_timeout", 32'(n < LIMIT), 1);
        @(posedge clk);
        #1;
        w_valid = 1'b0;
    endtask

    task automatic send_x(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        x_valid = 1'b1;
        x_data  = b;
        while (!x_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("x_timeout", 32'(n < LIMIT), 1);
        @(posedge clk);
        #1;
        x_valid = 1'b0;
    endtask

    task automatic recv_y(input logic [7:0] exp, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        y_ready = 1'b1;
        while (!y_valid && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("y_timeout", 32'(n < LIMIT), 1);
        check(tag, y_data, exp);
        #1;
        if (done) done_cnt++;
        @(posedge clk);
        #1;
        y_ready = 1'b0;
    endtask

    task automatic wait_mult_en();
        int n;
        n = 0;
        @(negedge clk);
        while (!mult_en && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("run_timeout", 32'(n < LIMIT), 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [W_BITS-1:0] w55;
        logic [W_BITS-1:0] wb;
        logic [7:0]        exp_b [OUT_LEN];
        int                n;

        w55   = {W_BYTES{8'h55}};
        wb    = '0;
        wb[58] = 1'b1;
        exp_b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00};

        w_valid = 1'b0;
        x_valid = 1'b0;
        y_ready = 1'b0;
        w_data  = 8'h00;
        x_data  = 8'h00;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_mult_en", mult_en, 0);
        check("rst_vec_in", mult_vec_in, 0);
        check("rst_mult_w", 32'(mult_w == '0), 1);
        check("rst_y_valid", y_valid, 0);
        check("rst_y_data", y_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_x_ready", x_ready, 1);
        check("rst_w_ready", w_ready, 1);
        check("rst_state", fsm_state, LOAD);
        check("rst_w_loaded", w_loaded, 0);
        rst_n = 1'b1;

        // Wraparound: all +1, x = 1..16, with weight gating during compute
        for (int i = 0; i < W_BYTES; i++) send_w(8'h55);
        check("a_w_loaded", w_loaded, 1);
        for (int i = 0; i < IN_LEN; i++) send_x(8'(i + 1));
        wait_mult_en();
        w_valid = 1'b1;
        w_data  = 8'hAA;
        for (int i = 0; i < 16; i++) begin
            check("gate_w_ready", w_ready, 0);
            check("gate_mult_w", 32'(mult_w === w55), 1);
            check("gate_mult_en", mult_en, 1);
            if (i == 0) check("a_pair0", mult_vec_in, 16'h0102);
            if (i == 3) check("a_pair3", mult_vec_in, 16'h0708);
            if (i == 7) check("a_pair7", mult_vec_in, 16'h0F10);
            if (i == 8) check("a_drain_vec", mult_vec_in, 16'h0000);
            if (i < 15) @(negedge clk);
        end
        w_valid = 1'b0;
        for (int i = 0; i < OUT_LEN; i++) recv_y(8'h88, "a_y");
        check("a_done_cnt", done_cnt, 1);
        check("a_err", err, 0);
        check("a_state", fsm_state, LOAD);

        // Single weight via a 31-byte reload that must hold off the start
        for (int i = 0; i < W_BYTES - 1; i++) send_w((i == 7) ? 8'h04 : 8'h00);
        for (int i = 0; i < IN_LEN; i++) send_x((i == 3) ? 8'h07 : 8'h00);
        repeat (5) @(negedge clk);
        check("b_blocked_state", fsm_state, LOAD);
        check("b_blocked_x_ready", x_ready, 0);
        check("b_blocked_mult_en", mult_en, 0);
        send_w(8'h00);
        check("b_mult_w", 32'(mult_w === wb), 1);
        wait_mult_en();
        for (int i = 0; i < OUT_LEN; i++) recv_y(exp_b[i], "b_y");
        check("b_done_cnt", done_cnt, 2);

        // Negative weights with output backpressure
        for (int i = 0; i < W_BYTES; i++) send_w(8'hFF);
        for (int i = 0; i < IN_LEN; i++) send_x(8'h01);
        wait_mult_en();
        n = 0;
        while (!y_valid && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("c_y_timeout", 32'(n < LIMIT), 1);
        for (int i = 0; i < 5; i++) begin
            check("c_hold_valid", y_valid, 1);
            check("c_hold_data", y_data, 8'hF0);
            @(negedge clk);
        end
        for (int i = 0; i < OUT_LEN; i++) recv_y(8'hF0, "c_y");
        check("c_done_cnt", done_cnt, 3);
        check("c_y_valid_after", y_valid, 0);
        check("c_state", fsm_state, LOAD);

        // Missing result-valid in DRAIN raises the sticky error
        drop_set = 1'b1;
        for (int i = 0; i < IN_LEN; i++) send_x(8'h01);
        wait_mult_en();
        for (int i = 0; i < OUT_LEN; i++) recv_y(8'hF0, "d_y");
        drop_set = 1'b0;
        check("d_err", err, 1);
        check("d_done_cnt", done_cnt, 4);
        repeat (2) @(negedge clk);
        check("d_err_sticky", err, 1);

        // Reset in RUN phase 4
        for (int i = 0; i < IN_LEN; i++) send_x(8'h02);
        wait_mult_en();
        repeat (4) @(negedge clk);
        check("e_pre_vec", mult_vec_in, 16'h0202);
        rst_n = 1'b0;
        #1;
        check("e_mult_en", mult_en, 0);
        check("e_busy", busy, 0);
        check("e_vec_in", mult_vec_in, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("e_state", fsm_state, LOAD);
        check("e_w_loaded", w_loaded, 0);
        check("e_x_ready", x_ready, 1);
        check("e_err", err, 0);
        check("e_mult_w", 32'(mult_w == '0), 1);
        repeat (3) @(negedge clk);
        check("e_idle_mult_en", mult_en, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
